// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared encodings for the single-port SRAM arbiter.
//   resp_e : response FSM state, i.e. which port was granted last cycle.
//   GNT_*  : grant encoding used between the grant mux, the response FSM
//            and the starvation counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_IM   = 2'd1,
    R_DM   = 2'd2
  } resp_e;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IM   = 2'd1;
  localparam logic [1:0] GNT_DM   = 2'd2;

  // Map a cycle-N grant to the response state for cycle N+1.
  function automatic resp_e resp_for_gnt(input logic [1:0] gnt);
    resp_e r;
    r = R_NONE;
    if (gnt == GNT_IM) r = R_IM;
    else if (gnt == GNT_DM) r = R_DM;
    return r;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr
//   Counts consecutive DM grants taken while IM is waiting and asks the
//   arbiter to let IM through once the streak reaches STARVE_LIMIT.
//   Only instantiated when ARB_STARVE_GUARD_EN is defined.
// Ports
//   clk       in   clock
//   rst       in   synchronous reset, active-high
//   im_req    in   IF fetch request
//   dm_req    in   MEM data request
//   gnt       in   grant chosen this cycle (GNT_* encoding)
//   force_im  out  1 = override DM priority and grant IM this cycle
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       im_req,
  input  logic       dm_req,
  input  logic [1:0] gnt,
  output logic       force_im
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] dm_streak;

  always_ff @(posedge clk) begin
    if (rst) begin
      dm_streak <= '0;
    end else if ((gnt == GNT_IM) || !im_req) begin
      dm_streak <= '0;
    end else if ((gnt == GNT_DM) && (dm_streak != LIMIT)) begin
      // saturate rather than wrap so a stuck streak can never hide
      dm_streak <= dm_streak + 1'b1;
    end
  end

  assign force_im = im_req && dm_req && (dm_streak == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port SRAM (1-cycle read latency) between the IF
//   fetch port (im_*) and the MEM data port (dm_*). Grants one port per
//   cycle, routes the SRAM read data back to the winner one cycle later,
//   and keeps a per-port hold register so stalled stages see stable data.
//   Optional feature: define ARB_STARVE_GUARD_EN to let IM through once
//   after STARVE_LIMIT consecutive DM grants while IM waits.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   im_req, im_address            fetch request / address
//   im_read_data, im_valid        fetched word / 1-cycle fresh pulse
//   im_stall                      fetch request present, not granted
//   dm_req, dm_w_en, dm_address,
//   dm_write_data                 load/store request (w_en==0 -> load)
//   dm_read_data, dm_valid        load word / fresh or store-done pulse
//   dm_stall                      data request present, not granted
//   mem_address, mem_w_en,
//   mem_write_data                SRAM command for the granted port
//   mem_read_data                 SRAM read data, one cycle after address
//
// Response FSM (resp_q)
//   state  | meaning
//   R_NONE | nothing granted last cycle, no response due
//   R_IM   | IM granted last cycle, mem_read_data is the fetched word
//   R_DM   | DM granted last cycle, load data (or store completion) due
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                im_req,
  input  logic [ADDR_W-1:0]   im_address,
  output logic [DATA_W-1:0]   im_read_data,
  output logic                im_valid,
  output logic                im_stall,
  input  logic                dm_req,
  input  logic [DATA_W/8-1:0] dm_w_en,
  input  logic [ADDR_W-1:0]   dm_address,
  input  logic [DATA_W-1:0]   dm_write_data,
  output logic [DATA_W-1:0]   dm_read_data,
  output logic                dm_valid,
  output logic                dm_stall,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_w_en,
  output logic [DATA_W-1:0]   mem_write_data,
  input  logic [DATA_W-1:0]   mem_read_data
);

  logic [1:0]        gnt;
  logic              force_im;
  resp_e             resp_q;
  logic              dm_load_q;
  logic [DATA_W-1:0] im_hold_q;
  logic [DATA_W-1:0] dm_hold_q;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .im_req   (im_req),
    .dm_req   (dm_req),
    .gnt      (gnt),
    .force_im (force_im)
  );
`else
  assign force_im = 1'b0;
`endif

  // DM wins by default: the MEM-stage instruction is older, so letting it
  // finish first is what keeps the pipeline from deadlocking. Nothing is
  // granted while in reset so no write can land during reset.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (dm_req && !force_im) gnt = GNT_DM;
      else if (im_req)         gnt = GNT_IM;
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_w_en       = '0;
    mem_write_data = '0;
    case (gnt)
      GNT_DM: begin
        mem_address    = dm_address;
        mem_w_en       = dm_w_en;
        mem_write_data = dm_write_data;
      end
      GNT_IM: begin
        mem_address = im_address;
      end
      default: ;
    endcase
  end

  assign im_stall = im_req && !rst && (gnt != GNT_IM);
  assign dm_stall = dm_req && !rst && (gnt != GNT_DM);

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q    <= R_NONE;
      dm_load_q <= 1'b0;
      im_hold_q <= '0;
      dm_hold_q <= '0;
    end else begin
      if (resp_q == R_IM) im_hold_q <= mem_read_data;
      // a completed store leaves the last load word in place
      if ((resp_q == R_DM) && dm_load_q) dm_hold_q <= mem_read_data;
      resp_q    <= resp_for_gnt(gnt);
      dm_load_q <= (gnt == GNT_DM) && (dm_w_en == '0);
    end
  end

  // Read data arrives from the SRAM in the response cycle itself, so the
  // fresh word is muxed straight through; the hold register covers every
  // other cycle. Reset forces all pipeline-facing outputs low, which also
  // drops a response that was due in the reset cycle.
  always_comb begin
    im_valid     = 1'b0;
    dm_valid     = 1'b0;
    im_read_data = '0;
    dm_read_data = '0;
    if (!rst) begin
      im_valid     = (resp_q == R_IM);
      dm_valid     = (resp_q == R_DM);
      im_read_data = im_valid ? mem_read_data : im_hold_q;
      dm_read_data = (dm_valid && dm_load_q) ? mem_read_data : dm_hold_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        im_req;
  logic [15:0] im_address;
  logic [31:0] im_read_data;
  logic        im_valid;
  logic        im_stall;
  logic        dm_req;
  logic [3:0]  dm_w_en;
  logic [15:0] dm_address;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;
  logic        dm_valid;
  logic        dm_stall;
  logic [15:0] mem_address;
  logic [3:0]  mem_w_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .im_req         (im_req),
    .im_address     (im_address),
    .im_read_data   (im_read_data),
    .im_valid       (im_valid),
    .im_stall       (im_stall),
    .dm_req         (dm_req),
    .dm_w_en        (dm_w_en),
    .dm_address     (dm_address),
    .dm_write_data  (dm_write_data),
    .dm_read_data   (dm_read_data),
    .dm_valid       (dm_valid),
    .dm_stall       (dm_stall),
    .mem_address    (mem_address),
    .mem_w_en       (mem_w_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        im_req;
    logic [15:0] im_addr;
    logic        dm_req;
    logic [3:0]  dm_w_en;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        exp_im_stall;
    logic        exp_dm_stall;
  } vec_t;

  typedef struct {
    logic        is_im;
    logic        is_load;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sram    [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] exp_im_hold;
  logic [31:0] exp_dm_hold;
  int          n_pass;
  int          n_total;

  function automatic int widx(input logic [15:0] a);
    return int'(a[15:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // SRAM macro model: byte-enabled write, write-first read, 1-cycle latency
  always @(posedge clk) begin
    if (mem_w_en != 4'h0) sram[widx(mem_address)] = merge(sram[widx(mem_address)], mem_write_data, mem_w_en);
    mem_read_data <= sram[widx(mem_address)];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Compare this cycle's response outputs against the scoreboard head.
  task automatic check_resp(input string name);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_im) begin
        chk({name, " im_valid"}, 32'(im_valid), 32'd1);
        chk({name, " dm_valid"}, 32'(dm_valid), 32'd0);
        chk({name, " im_read_data"}, im_read_data, e.data);
        exp_im_hold = e.data;
        chk({name, " dm_hold"}, dm_read_data, exp_dm_hold);
      end else begin
        chk({name, " dm_valid"}, 32'(dm_valid), 32'd1);
        chk({name, " im_valid"}, 32'(im_valid), 32'd0);
        if (e.is_load) exp_dm_hold = e.data;
        chk({name, " dm_read_data"}, dm_read_data, exp_dm_hold);
        chk({name, " im_hold"}, im_read_data, exp_im_hold);
      end
    end else begin
      chk({name, " im_valid idle"}, 32'(im_valid), 32'd0);
      chk({name, " dm_valid idle"}, 32'(dm_valid), 32'd0);
      chk({name, " im_hold"}, im_read_data, exp_im_hold);
      chk({name, " dm_hold"}, dm_read_data, exp_dm_hold);
    end
  endtask

  // Drive one cycle of requests just after a falling edge, check, then
  // advance to the next falling edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    im_req        = v.im_req;
    im_address    = v.im_addr;
    dm_req        = v.dm_req;
    dm_w_en       = v.dm_w_en;
    dm_address    = v.dm_addr;
    dm_write_data = v.dm_wdata;
    #2;
    check_resp(name);
    chk({name, " im_stall"}, 32'(im_stall), 32'(v.exp_im_stall));
    chk({name, " dm_stall"}, 32'(dm_stall), 32'(v.exp_dm_stall));
    if (v.dm_req && !v.exp_dm_stall) begin
      chk({name, " mem_address dm"}, 32'(mem_address), 32'(v.dm_addr));
      chk({name, " mem_w_en dm"}, 32'(mem_w_en), 32'(v.dm_w_en));
      if (v.dm_w_en != 4'h0)
        ref_mem[widx(v.dm_addr)] = merge(ref_mem[widx(v.dm_addr)], v.dm_wdata, v.dm_w_en);
      e.is_im   = 1'b0;
      e.is_load = (v.dm_w_en == 4'h0);
      e.data    = ref_mem[widx(v.dm_addr)];
      sb.push_back(e);
    end else if (v.im_req && !v.exp_im_stall) begin
      chk({name, " mem_address im"}, 32'(mem_address), 32'(v.im_addr));
      chk({name, " mem_w_en im"}, 32'(mem_w_en), 32'd0);
      e.is_im   = 1'b1;
      e.is_load = 1'b1;
      e.data    = ref_mem[widx(v.im_addr)];
      sb.push_back(e);
    end else begin
      chk({name, " mem_address idle"}, 32'(mem_address), 32'd0);
      chk({name, " mem_w_en idle"}, 32'(mem_w_en), 32'd0);
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic ir, input logic [15:0] ia, input logic dr,
                              input logic [3:0] we, input logic [15:0] da,
                              input logic [31:0] wd, input logic eis, input logic eds);
    vec_t v;
    v.im_req = ir; v.im_addr = ia; v.dm_req = dr; v.dm_w_en = we;
    v.dm_addr = da; v.dm_wdata = wd; v.exp_im_stall = eis; v.exp_dm_stall = eds;
    return v;
  endfunction

  vec_t vecs [19];

  initial begin
    n_pass = 0;
    n_total = 0;
    exp_im_hold = '0;
    exp_dm_hold = '0;
    for (int i = 0; i < 16384; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    sram[widx(16'h0040)] = 32'h00A00093; ref_mem[widx(16'h0040)] = 32'h00A00093;
    sram[widx(16'h0044)] = 32'h00B00113; ref_mem[widx(16'h0044)] = 32'h00B00113;
    sram[widx(16'h0048)] = 32'h13579BDF; ref_mem[widx(16'h0048)] = 32'h13579BDF;
    sram[widx(16'h0100)] = 32'hDEADBEEF; ref_mem[widx(16'h0100)] = 32'hDEADBEEF;
    sram[widx(16'h0300)] = 32'h11223344; ref_mem[widx(16'h0300)] = 32'h11223344;

    //              im  im_addr   dm  w_en   dm_addr   wdata          eis  eds
    vecs[0]  = mk(0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[1]  = mk(1, 16'h0040, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[2]  = mk(0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[3]  = mk(1, 16'h0044, 1, 4'h0, 16'h0100, 32'h0,          1,   0);
    vecs[4]  = mk(1, 16'h0044, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[5]  = mk(0, 16'h0000, 1, 4'hF, 16'h0200, 32'h12345678,   0,   0);
    vecs[6]  = mk(0, 16'h0000, 1, 4'h0, 16'h0200, 32'h0,          0,   0);
    vecs[7]  = mk(0, 16'h0000, 1, 4'h3, 16'h0300, 32'hFFFFAAAA,   0,   0);
    vecs[8]  = mk(0, 16'h0000, 1, 4'h0, 16'h0300, 32'h0,          0,   0);
    vecs[9]  = mk(0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[10] = mk(0, 16'h0000, 1, 4'hF, 16'h0204, 32'hCAFEF00D,   0,   0);
    vecs[11] = mk(1, 16'h0204, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[12] = mk(0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[13] = mk(0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[14] = mk(0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[15] = mk(0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[16] = mk(1, 16'h0048, 1, 4'hF, 16'h0208, 32'h0BADCAFE,   1,   0);
    vecs[17] = mk(1, 16'h0048, 0, 4'h0, 16'h0000, 32'h0,          0,   0);
    vecs[18] = mk(0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0,          0,   0);

    rst = 1'b1;
    im_req = 1'b0; im_address = '0;
    dm_req = 1'b0; dm_w_en = '0; dm_address = '0; dm_write_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("reset im_valid", 32'(im_valid), 32'd0);
    chk("reset dm_valid", 32'(dm_valid), 32'd0);
    chk("reset im_read_data", im_read_data, 32'd0);
    chk("reset dm_read_data", dm_read_data, 32'd0);
    chk("reset resp_q", 32'(dut.resp_q), 32'(R_NONE));
    @(negedge clk);

    for (int i = 0; i < 19; i++) apply(vecs[i], $sformatf("v%0d", i));

    // both ports requesting continuously
    begin
      int   b_streak;
      logic im_wins;
      b_streak = 0;
      for (int k = 0; k < 12; k++) begin
`ifdef ARB_STARVE_GUARD_EN
        im_wins  = (b_streak == int'(STARVE_LIMIT));
        b_streak = im_wins ? 0 : b_streak + 1;
`else
        im_wins  = 1'b0;
`endif
        apply(mk(1, 16'h0040, 1, 4'h0, 16'h0100, 32'h0, !im_wins, im_wins),
              $sformatf("starve%0d", k));
      end
      apply(mk(0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0, 0, 0), "starve_drain");
    end

    // reset the cycle after a load grant: response is dropped
    apply(mk(0, 16'h0000, 1, 4'h0, 16'h0300, 32'h0, 0, 0), "pre_rst_load");
    rst = 1'b1;
    im_req = 1'b0;
    dm_req = 1'b0;
    #2;
    chk("rst dm_valid", 32'(dm_valid), 32'd0);
    chk("rst dm_read_data", dm_read_data, 32'd0);
    chk("rst im_read_data", im_read_data, 32'd0);
    sb.delete();
    exp_im_hold = '0;
    exp_dm_hold = '0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post_rst dm_valid", 32'(dm_valid), 32'd0);
    chk("post_rst dm_read_data", dm_read_data, 32'd0);
    chk("post_rst resp_q", 32'(dut.resp_q), 32'(R_NONE));
    @(negedge clk);
    apply(mk(0, 16'h0000, 0, 4'h0, 16'h0000, 32'h0, 0, 0), "post_rst_idle");

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
